// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: walks an active-low column strobe, debounces one
// pressed key, emits a single key_valid pulse per press and holds key_held until release.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV     = 100000,
  parameter int DEBOUNCE_CNT = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held,
  output logic [1:0] dbg_state
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HELD     = 2'd2
  } state_t;

  state_t          state_q;
  logic [3:0]      row_meta_q;
  logic [3:0]      row_s_q;
  logic [DW-1:0]   div_cnt_q;
  logic [CW-1:0]   deb_cnt_q;
  logic [3:0]      col_q;
  logic [1:0]      col_idx_q;
  logic [1:0]      row_idx_q;
  logic [3:0]      pat_q;
  logic            key_valid_q;
  logic [3:0]      key_code_q;
  logic            key_held_q;

  logic            tick;
  logic            row_valid;
  logic [1:0]      row_idx_d;
  logic [CW-1:0]   deb_cnt_d;

  assign tick      = (div_cnt_q == DW'(SCAN_DIV - 1));
  assign deb_cnt_d = deb_cnt_q + CW'(1);

  // Only a single low row is a usable press; idle and ghost patterns fall through.
  always_comb begin
    row_valid = 1'b1;
    row_idx_d = 2'd0;
    case (row_s_q)
      4'b1110: row_idx_d = 2'd0;
      4'b1101: row_idx_d = 2'd1;
      4'b1011: row_idx_d = 2'd2;
      4'b0111: row_idx_d = 2'd3;
      default: row_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_SCAN;
      row_meta_q  <= 4'hF;
      row_s_q     <= 4'hF;
      div_cnt_q   <= '0;
      deb_cnt_q   <= '0;
      col_q       <= 4'b1110;
      col_idx_q   <= 2'd0;
      row_idx_q   <= 2'd0;
      pat_q       <= 4'hF;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
      key_held_q  <= 1'b0;
    end else begin
      row_meta_q  <= row;
      row_s_q     <= row_meta_q;
      div_cnt_q   <= tick ? '0 : div_cnt_q + DW'(1);
      key_valid_q <= 1'b0;
      if (tick) begin
        case (state_q)
          S_SCAN: begin
            if (row_valid) begin
              pat_q     <= row_s_q;
              row_idx_q <= row_idx_d;
              deb_cnt_q <= '0;
              state_q   <= S_DEBOUNCE;
            end else begin
              col_q     <= {col_q[2:0], col_q[3]};
              col_idx_q <= col_idx_q + 2'd1;
            end
          end
          S_DEBOUNCE: begin
            if (row_s_q == pat_q) begin
              if (deb_cnt_d == CW'(DEBOUNCE_CNT - 1)) begin
                state_q     <= S_HELD;
                key_code_q  <= {row_idx_q, col_idx_q};
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                deb_cnt_q   <= '0;
              end else begin
                deb_cnt_q <= deb_cnt_d;
              end
            end else begin
              state_q   <= S_SCAN;
              col_q     <= {col_q[2:0], col_q[3]};
              col_idx_q <= col_idx_q + 2'd1;
            end
          end
          S_HELD: begin
            // Any non-idle sample restarts the release count, so a second key is ignored.
            if (row_s_q == 4'hF) begin
              if (deb_cnt_d == CW'(DEBOUNCE_CNT)) begin
                state_q    <= S_SCAN;
                key_held_q <= 1'b0;
                deb_cnt_q  <= '0;
                col_q      <= {col_q[2:0], col_q[3]};
                col_idx_q  <= col_idx_q + 2'd1;
              end else begin
                deb_cnt_q <= deb_cnt_d;
              end
            end else begin
              deb_cnt_q <= '0;
            end
          end
          default: state_q <= S_SCAN;
        endcase
      end
    end
  end

  assign col       = col_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_held  = key_held_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl: a key-matrix model drives row from col,
// a vector table covers scan, press, hold, release, ghost and bounce cases.
module tb_keypad_scan_ctrl;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row;
  logic [3:0] col;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;
  logic [1:0] dbg_state;

  logic [15:0] keys;  // bit r*4+c set = key at row r, column c is down
  int n_pass = 0;
  int n_total = 0;
  int vcnt = 0;
  int werr = 0;
  logic prev_v = 1'b0;

  typedef struct {
    logic [15:0] keys;
    int          ticks;
    logic [3:0]  col;
    logic        held;
    logic [3:0]  code;
    logic [1:0]  state;
    int          vd;
  } vec_t;

  vec_t vq[$];

  keypad_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT)) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Passive matrix: a down key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  function automatic vec_t mk(logic [15:0] k, int t, logic [3:0] cl, logic h,
                              logic [3:0] cd, logic [1:0] st, int vd);
    vec_t v;
    v.keys = k; v.ticks = t; v.col = cl; v.held = h;
    v.code = cd; v.state = st; v.vd = vd;
    return v;
  endfunction

  task automatic check(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Each clock: advance past the rising edge, then sample on the falling edge.
  task automatic run_clks(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (key_valid) vcnt++;
      if (key_valid && prev_v) werr++;
      prev_v = key_valid;
    end
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_col"},   col,       4'b1110);
    check({tag, "_valid"}, key_valid, 0);
    check({tag, "_code"},  key_code,  0);
    check({tag, "_held"},  key_held,  0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  initial begin
    int v0;
    // Scenario 1 tail, 2 press/hold, 3 release, 5 ghost, 4 bounce
    vq.push_back(mk(16'h0000,  1, 4'b1011, 1'b0, 4'h0, 2'd0, 0));
    vq.push_back(mk(16'h0000,  1, 4'b0111, 1'b0, 4'h0, 2'd0, 0));
    vq.push_back(mk(16'h0000,  1, 4'b1110, 1'b0, 4'h0, 2'd0, 0));
    vq.push_back(mk(16'h0200,  3, 4'b1101, 1'b0, 4'h0, 2'd1, 0));
    vq.push_back(mk(16'h0200,  1, 4'b1101, 1'b1, 4'h9, 2'd2, 1));
    vq.push_back(mk(16'h0200, 50, 4'b1101, 1'b1, 4'h9, 2'd2, 0));
    vq.push_back(mk(16'h0000,  2, 4'b1101, 1'b1, 4'h9, 2'd2, 0));
    vq.push_back(mk(16'h0000,  1, 4'b1011, 1'b0, 4'h9, 2'd0, 0));
    vq.push_back(mk(16'h0011,  2, 4'b1110, 1'b0, 4'h9, 2'd0, 0));
    vq.push_back(mk(16'h0011,  1, 4'b1101, 1'b0, 4'h9, 2'd0, 0));
    vq.push_back(mk(16'h0011,  4, 4'b1101, 1'b0, 4'h9, 2'd0, 0));
    vq.push_back(mk(16'h0000,  2, 4'b0111, 1'b0, 4'h9, 2'd0, 0));
    vq.push_back(mk(16'h0008,  1, 4'b0111, 1'b0, 4'h9, 2'd1, 0));
    vq.push_back(mk(16'h0000,  1, 4'b1110, 1'b0, 4'h9, 2'd0, 0));
    vq.push_back(mk(16'h0000,  3, 4'b0111, 1'b0, 4'h9, 2'd0, 0));
    vq.push_back(mk(16'h0008,  1, 4'b0111, 1'b0, 4'h9, 2'd1, 0));
    vq.push_back(mk(16'h0000,  1, 4'b1110, 1'b0, 4'h9, 2'd0, 0));
    vq.push_back(mk(16'h0000,  3, 4'b0111, 1'b0, 4'h9, 2'd0, 0));
    vq.push_back(mk(16'h0008,  2, 4'b0111, 1'b0, 4'h9, 2'd1, 0));
    vq.push_back(mk(16'h0000,  1, 4'b1110, 1'b0, 4'h9, 2'd0, 0));

    keys  = 16'h0000;
    reset = 1'b1;
    run_clks(3);
    check_reset_vals("por");
    reset = 1'b0;

    run_clks(3);
    check("col_hold_3clk", col, 4'b1110);
    run_clks(1);
    check("col_rot_4clk", col, 4'b1101);

    foreach (vq[i]) begin
      keys = vq[i].keys;
      v0 = vcnt;
      run_clks(4 * vq[i].ticks);
      check($sformatf("v%0d_col", i),   col,       vq[i].col);
      check($sformatf("v%0d_held", i),  key_held,  vq[i].held);
      check($sformatf("v%0d_code", i),  key_code,  vq[i].code);
      check($sformatf("v%0d_state", i), dbg_state, vq[i].state);
      check($sformatf("v%0d_vcnt", i),  vcnt - v0, vq[i].vd);
    end

    // Reset while debouncing key r0c0
    keys = 16'h0001;
    run_clks(4);
    check("rstdeb_pre_state", dbg_state, 1);
    keys  = 16'h0000;
    reset = 1'b1;
    v0 = vcnt;
    run_clks(1);
    check_reset_vals("rstdeb");
    reset = 1'b0;
    run_clks(16);
    check("rstdeb_post_col", col, 4'b1110);
    check("rstdeb_post_vcnt", vcnt - v0, 0);

    // Reset while holding key r3c0
    keys = 16'h1000;
    v0 = vcnt;
    run_clks(12);
    check("rsthld_pre_state", dbg_state, 2);
    check("rsthld_pre_held", key_held, 1);
    check("rsthld_pre_code", key_code, 4'hC);
    check("rsthld_pre_vcnt", vcnt - v0, 1);
    keys  = 16'h0000;
    reset = 1'b1;
    v0 = vcnt;
    run_clks(1);
    check_reset_vals("rsthld");
    reset = 1'b0;
    run_clks(20);
    check("rsthld_post_col", col, 4'b1101);
    check("rsthld_post_held", key_held, 0);
    check("rsthld_post_vcnt", vcnt - v0, 0);

    check("pulse_width_errs", werr, 0);
    check("total_valids", vcnt, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Scan sequencer and debouncer for the 4x4 matrix keypad. It drives the column lines one at a time, samples the row lines, debounces a single pressed key, and emits one `key_valid` pulse with a 4-bit key code per press. It holds `key_held` until release. It sits between the keypad pins and the keypad consumers: LED/seven-segment display logic and password checking. Mapping a key code to a legend is done downstream.

## Interface
Parameters:
- `SCAN_DIV`, default 100000: clock cycles per scan tick (1 ms at 100 MHz). Legal range is ≥ 4.
- `DEBOUNCE_CNT`, default 20: number of consecutive agreeing tick samples needed to accept a press or a release. Legal range is ≥ 2.

Ports:
- `clk`, input, 1: single clock. Everything is synchronous to its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `row`, input, 4: keypad row pins, active-low, pulled up. Asynchronous to `clk`.
- `col`, output, 4: keypad column drive, one-hot active-low.
- `key_valid`, output, 1: one-cycle pulse marking an accepted press.
- `key_code`, output, 4: `{row_idx[1:0], col_idx[1:0]}` of the last accepted key. Held stable between presses.
- `key_held`, output, 1: high from the `key_valid` cycle until the release is debounced.

## Operation
- Row synchronizer:
  - `row` passes through two flops to give `row_s`. Both flops reset to 4'hF.
  - All decisions use `row_s` only.
- Tick generator:
  - `div_cnt` counts 0 to `SCAN_DIV`-1 and wraps.
  - `tick` is high when `div_cnt == SCAN_DIV-1`.
  - `div_cnt` free-runs in all states and clears on reset.
- Valid row pattern: `row_s` has exactly one zero bit (1110, 1101, 1011 or 0111). `row_idx` is the position of that zero.
- State machine has three states: SCAN, DEBOUNCE, HELD. Reset state is SCAN.
- SCAN:
  - On `tick` with a valid row pattern: latch `row_idx` and the current `col_idx`, clear `deb_cnt`, go to DEBOUNCE. `col` freezes.
  - On `tick` with `row_s == 4'hF`, or more than one zero (ghost/multi-key): stay in SCAN and rotate `col`.
  - Rotation order: 1110 → 1101 → 1011 → 0111 → 1110. `col_idx` goes 0 → 1 → 2 → 3 → 0.
- DEBOUNCE:
  - On `tick`, if `row_s` equals the latched pattern: `deb_cnt` increments.
  - When the incremented value would reach `DEBOUNCE_CNT`-1: go to HELD. In that same transition, register `key_code` and pulse `key_valid`.
  - On `tick` with a mismatch: return to SCAN and rotate `col`. No pulse is emitted.
- HELD:
  - `col` stays frozen and `key_held` = 1.
  - On `tick` with `row_s == 4'hF`: `deb_cnt` increments. Any other value clears `deb_cnt`.
  - When `DEBOUNCE_CNT` consecutive released ticks are seen: go to SCAN and rotate `col`. `key_held` drops on entry to SCAN.
- A press always produces exactly one `key_valid`, however long the key is held.
- A second key pressed while in HELD is ignored. Rescanning starts only after a full release.

## Timing
Reset values:
- `col` = 4'b1110
- `key_valid` = 0
- `key_code` = 4'h0
- `key_held` = 0
- `div_cnt` = 0
- `deb_cnt` = 0
- state = SCAN

Reset behaviour:
- Reset takes effect at the first rising edge with `reset` high, including in the middle of DEBOUNCE or HELD.
- No `key_valid` is produced on or after that edge until a new press completes debounce.

Cycle-level timing:
- `col`, `key_valid`, `key_code` and `key_held` are all registered. Each changes on the edge that ends the `tick` cycle.
- `key_valid` is high for exactly one cycle. `key_code` is valid in that same cycle.
- Pin-to-decision latency is 2 cycles (synchronizer). `SCAN_DIV` ≥ 4 guarantees that `row_s` reflects the current `col` drive at each tick.
- Press latency from the first tick seeing the key to `key_valid` is `DEBOUNCE_CNT`-1 ticks. The SCAN→DEBOUNCE tick counts as the first agreeing sample.
- Release latency is `DEBOUNCE_CNT` ticks of continuous 4'hF.

## Test plan
Bench settings: `SCAN_DIV`=4, `DEBOUNCE_CNT`=3.

1. Reset release with no key pressed → `col` cycles 1110, 1101, 1011, 0111 every 4 clocks; `key_valid` never asserts.
2. Hold row 2 low while col 1 is driven, steady for 50 ticks → exactly one `key_valid` with `key_code` = 4'h9; `key_held` = 1; `col` frozen at 1101.
3. Release the key from scenario 2 → `key_held` drops 3 ticks later and column rotation resumes at 1011.
4. Bounce row 0 on col 3 (low for 1 tick, high for 1 tick, repeated) → no `key_valid`; state returns to SCAN each time.
5. Assert rows 0 and 1 low together on col 0 → no `key_valid`; scan continues.
6. Reset pulse in the middle of DEBOUNCE, and separately in HELD → outputs return to reset values on the next edge; no `key_valid` is emitted for the interrupted press.
